pattern_generator: RTL and testbench
====================================

# pattern_generator

Synthetic data source that fills the PATTERN FIFO, i.e. the writer whose read side feeds the DDR converter path when pattern mode is selected. On a start pulse it emits a fixed number of events. Each event is one header word followed by a programmable number of deterministic payload words. It writes at up to one word per clock and honours FIFO back-pressure, so DDR, converter and readout can be exercised without DIGIFIFO traffic.

## Interface
- NWORDS_W, 17: payload-length width; matches the FIFO read-count width.
- NEVENTS_W, 16: event-count width.
- HDR_TAG, 8'hE5: tag in header bits [31:24].

- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- pattern_en  in  1  pattern mode enable; the same signal drives the FIFO output selection.
- pattern_start  in  1  one-cycle start pulse.
- pattern_nwords  in  NWORDS_W  payload words per event; latched at start.
- pattern_nevents  in  NEVENTS_W  events per run; latched at start.
- PATTERN_full  in  1  PATTERN FIFO full flag.
- PATTERN_we  out  1  FIFO write enable.
- PATTERN_data  out  32  FIFO write data.
- pattern_busy  out  1  run in progress.
- pattern_done  out  1  one-cycle pulse when a run completes.
- pattern_evcnt  out  NEVENTS_W  number of events fully written in the current or last run.

## Operation
- States:
  - IDLE: waits for a start.
  - HEADER: writes the header word.
  - PAYLOAD: writes payload words.
  - DONE: asserts pattern_done, then returns to IDLE.
- IDLE -> HEADER requires pattern_start=1 and pattern_en=1. At the start edge, nwords and nevents are latched, ev=0, idx=0, and pattern_evcnt is cleared.
- pattern_start in IDLE with latched nevents=0 (sampled at start): goes IDLE -> DONE. No writes occur.
- pattern_start while busy, or while pattern_en=0: ignored.
- Header word: {HDR_TAG, 7'b0, nwords_latched}.
- Payload word idx: {ev[14:0], idx[16:0]}. idx runs 0..nwords-1 and restarts at 0 for each event. ev wraps in the payload field only.
- A write occurs when PATTERN_we=1. PATTERN_we = (state is HEADER or PAYLOAD) && !PATTERN_full && pattern_en. It is combinational so the FIFO is never overrun. PATTERN_data is valid whenever PATTERN_we=1.
- State advances only on a write:
  - HEADER -> PAYLOAD, or if nwords=0 straight to end-of-event.
  - PAYLOAD stays in PAYLOAD and increments idx until idx=nwords-1, then goes to end-of-event.
- End-of-event: pattern_evcnt increments. If ev+1 < nevents, go to HEADER with ev+1 and idx=0; otherwise go to DONE.
- pattern_en deasserted in any non-IDLE state: abort to IDLE on the next edge. No further writes, no done pulse. pattern_evcnt holds its value.
- Total writes per completed run = nevents*(nwords+1).

## Timing
- Reset values: PATTERN_we=0, PATTERN_data=0, pattern_busy=0, pattern_done=0, pattern_evcnt=0, state IDLE.
- Start pulse sampled at edge N: busy=1 from cycle N+1. The first header write can occur in cycle N+1.
- Throughput: one word per cycle while PATTERN_full=0, with no bubbles between events.
- PATTERN_full high: PATTERN_we=0 in that same cycle. Data, state and counters are held. Resume is immediate when full drops.
- Last write in cycle M: DONE in M+1 with pattern_done=1 and busy=0 from M+1. IDLE in M+2; a new start is accepted from M+2.
- Asynchronous reset mid-run: all outputs return to reset values immediately. Any partial event remains in the FIFO; flushing it is software's responsibility.

## Test plan
- nwords=3, nevents=2, full=0. Writes are E5000003, 00000000, 00000001, 00000002, E5000003, 00020000, 00020001, 00020002 on 8 consecutive cycles. Done pulses one cycle after the last write; evcnt=2.
- Same run with PATTERN_full forced high for 5 cycles mid-payload. we=0 during the stall, no word is lost or duplicated, and the sequence is identical.
- nwords=0, nevents=4. Four header writes E5000000 back-to-back, then done; evcnt=4.
- nevents=0 start. Zero writes, done one cycle after start, busy never high.
- pattern_en dropped after the 5th write of an nwords=10, nevents=3 run. Writes stop the same cycle, no done, back in IDLE next cycle, evcnt=0. A restart regenerates the run from ev=0.
- reset_n pulsed low mid-payload. All outputs are 0 asynchronously. pattern_start repeated while busy has no effect.

Source files
------------

// File: rtl/pattern_generator.sv
// Synthetic PATTERN FIFO writer: per run, emits nevents events of one header word
// followed by nwords deterministic payload words, one word per clock, stalling on full.
module pattern_generator #(
    parameter int         NWORDS_W  = 17,
    parameter int         NEVENTS_W = 16,
    parameter logic [7:0] HDR_TAG   = 8'hE5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pattern_en,
    input  logic                 pattern_start,
    input  logic [NWORDS_W-1:0]  pattern_nwords,
    input  logic [NEVENTS_W-1:0] pattern_nevents,
    input  logic                 PATTERN_full,
    output logic                 PATTERN_we,
    output logic [31:0]          PATTERN_data,
    output logic                 pattern_busy,
    output logic                 pattern_done,
    output logic [NEVENTS_W-1:0] pattern_evcnt
);

    localparam int HDR_PAD_W  = 24 - NWORDS_W;
    localparam int EV_FIELD_W = 32 - NWORDS_W;

    localparam logic [NWORDS_W-1:0]  NW_ONE = {{(NWORDS_W-1){1'b0}}, 1'b1};
    localparam logic [NEVENTS_W:0]   NE_ONE = {{NEVENTS_W{1'b0}}, 1'b1};
    localparam logic [NEVENTS_W-1:0] EV_ONE = {{(NEVENTS_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [NWORDS_W-1:0]    nwords_reg, nwords_next;
    logic [NEVENTS_W-1:0]   nevents_reg, nevents_next;
    logic [NEVENTS_W-1:0]   ev_reg, ev_next;
    logic [NWORDS_W-1:0]    idx_reg, idx_next;
    logic [NEVENTS_W-1:0]   evcnt_reg, evcnt_next;

    logic start_ok;
    logic active;
    logic wr_en;
    logic last_word;
    logic more_events;

    assign start_ok = (state_reg == S_IDLE) && pattern_start && pattern_en;
    assign active   = (state_reg == S_HEADER) || (state_reg == S_PAYLOAD);
    // Write enable is combinational on full so the FIFO can never be overrun.
    assign wr_en    = active && !PATTERN_full && pattern_en;

    // Last word of an event: a bare header when nwords=0, else the final payload word.
    assign last_word = (state_reg == S_HEADER) ? (nwords_reg == '0)
                                               : (idx_reg == (nwords_reg - NW_ONE));
    assign more_events = ({1'b0, ev_reg} + NE_ONE) < {1'b0, nevents_reg};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = (pattern_nevents == '0) ? S_DONE : S_HEADER;
                end
            end
            S_HEADER, S_PAYLOAD: begin
                if (!pattern_en) begin
                    state_next = S_IDLE;
                end else if (wr_en) begin
                    if (last_word) begin
                        state_next = more_events ? S_HEADER : S_DONE;
                    end else begin
                        state_next = S_PAYLOAD;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        PATTERN_we    = wr_en;
        PATTERN_data  = 32'd0;
        pattern_busy  = active;
        pattern_done  = (state_reg == S_DONE);
        pattern_evcnt = evcnt_reg;
        case (state_reg)
            S_HEADER:  PATTERN_data = {HDR_TAG, {HDR_PAD_W{1'b0}}, nwords_reg};
            // Event number wraps inside the payload field only.
            S_PAYLOAD: PATTERN_data = {ev_reg[EV_FIELD_W-1:0], idx_reg};
            default:   PATTERN_data = 32'd0;
        endcase
    end

    // Run parameters and event/word counters; everything holds while stalled.
    always_comb begin
        nwords_next  = nwords_reg;
        nevents_next = nevents_reg;
        ev_next      = ev_reg;
        idx_next     = idx_reg;
        evcnt_next   = evcnt_reg;
        if (start_ok) begin
            nwords_next  = pattern_nwords;
            nevents_next = pattern_nevents;
            ev_next      = '0;
            idx_next     = '0;
            evcnt_next   = '0;
        end else if (wr_en) begin
            if (last_word) begin
                evcnt_next = evcnt_reg + EV_ONE;
                idx_next   = '0;
                if (more_events) begin
                    ev_next = ev_reg + EV_ONE;
                end
            end else if (state_reg == S_PAYLOAD) begin
                idx_next = idx_reg + NW_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nwords_reg  <= '0;
            nevents_reg <= '0;
            ev_reg      <= '0;
            idx_reg     <= '0;
            evcnt_reg   <= '0;
        end else begin
            nwords_reg  <= nwords_next;
            nevents_reg <= nevents_next;
            ev_reg      <= ev_next;
            idx_reg     <= idx_next;
            evcnt_reg   <= evcnt_next;
        end
    end

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: directed scenarios plus randomized runs, each write
// compared against an expected word list built from the event/word arithmetic.
module tb_pattern_generator;

    logic        clk;
    logic        reset_n;
    logic        pattern_en;
    logic        pattern_start;
    logic [16:0] pattern_nwords;
    logic [15:0] pattern_nevents;
    logic        PATTERN_full;
    logic        PATTERN_we;
    logic [31:0] PATTERN_data;
    logic        pattern_busy;
    logic        pattern_done;
    logic [15:0] pattern_evcnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] got_q[$];
    logic [31:0] plan1_words[8] = '{32'hE500_0003, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002,
                                    32'hE500_0003, 32'h0002_0000, 32'h0002_0001, 32'h0002_0002};

    pattern_generator dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pattern_en      (pattern_en),
        .pattern_start   (pattern_start),
        .pattern_nwords  (pattern_nwords),
        .pattern_nevents (pattern_nevents),
        .PATTERN_full    (PATTERN_full),
        .PATTERN_we      (PATTERN_we),
        .PATTERN_data    (PATTERN_data),
        .pattern_busy    (pattern_busy),
        .pattern_done    (pattern_done),
        .pattern_evcnt   (pattern_evcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " we"},    32'(PATTERN_we),    0);
        check({tag, " data"},  PATTERN_data,       0);
        check({tag, " busy"},  32'(pattern_busy),  0);
        check({tag, " done"},  32'(pattern_done),  0);
        check({tag, " evcnt"}, 32'(pattern_evcnt), 0);
    endtask

    task automatic pulse_start(input int nw, input int ne);
        @(posedge clk); #1;
        PATTERN_full    = 1'b0;
        pattern_nwords  = 17'(nw);
        pattern_nevents = 16'(ne);
        pattern_start   = 1'b1;
        @(posedge clk); #1;
        pattern_start   = 1'b0;
        // Scramble the inputs: the run must use the values latched at start.
        pattern_nwords  = 17'($urandom);
        pattern_nevents = 16'($urandom);
    endtask

    // One full run checked cycle by cycle against the expected word list.
    task automatic run_stream(input string tag, input int nw, input int ne, input int full_pct,
                              input int stall_at, input int stall_len, input int spur_at);
        logic [31:0] exp_q[$];
        int written;
        int budget;
        int cyc;
        bit done_seen;
        bit full;
        bit exp_active;
        exp_q = {};
        for (int e = 0; e < ne; e++) begin
            exp_q.push_back(32'hE500_0000 + 32'(nw));
            for (int i = 0; i < nw; i++) begin
                exp_q.push_back(32'((e % 32768) * 131072 + i));
            end
        end
        got_q = {};
        written = 0;
        done_seen = 0;
        budget = (ne * (nw + 1) + 2) * 10 + stall_len + 10;
        pulse_start(nw, ne);
        for (cyc = 1; cyc <= budget && !done_seen; cyc++) begin
            full = ($urandom_range(0, 99) < full_pct) ||
                   (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            PATTERN_full  = full;
            pattern_start = (cyc == spur_at);
            @(negedge clk);
            exp_active = (written < exp_q.size());
            check({tag, " busy"},  32'(pattern_busy),  32'(exp_active));
            check({tag, " done"},  32'(pattern_done),  32'(!exp_active));
            check({tag, " we"},    32'(PATTERN_we),    32'(exp_active && !full));
            check({tag, " evcnt"}, 32'(pattern_evcnt), 32'(written / (nw + 1)));
            if (PATTERN_we) begin
                got_q.push_back(PATTERN_data);
                if (written < exp_q.size())
                    check($sformatf("%s word%0d", tag, written), PATTERN_data, exp_q[written]);
                written++;
            end
            if (pattern_done) done_seen = 1;
            @(posedge clk); #1;
        end
        pattern_start = 1'b0;
        PATTERN_full  = 1'b0;
        check({tag, " done_reached"}, 32'(done_seen), 1);
        check({tag, " total_writes"}, 32'(written), 32'(ne * (nw + 1)));
        @(negedge clk);
        check({tag, " idle busy"}, 32'(pattern_busy), 0);
        check({tag, " idle done"}, 32'(pattern_done), 0);
        $display("run %s nwords=%0d nevents=%0d writes=%0d cycles=%0d", tag, nw, ne, written, cyc - 1);
    endtask

    initial begin
        int n;
        reset_n         = 1'b0;
        pattern_en      = 1'b1;
        pattern_start   = 1'b0;
        pattern_nwords  = '0;
        pattern_nevents = '0;
        PATTERN_full    = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        run_stream("plan1", 3, 2, 0, 0, 0, 0);
        check("plan1 count", 32'(got_q.size()), 8);
        for (int k = 0; k < 8; k++)
            if (k < got_q.size()) check($sformatf("plan1 lit%0d", k), got_q[k], plan1_words[k]);

        run_stream("stall", 3, 2, 0, 4, 5, 0);
        check("stall count", 32'(got_q.size()), 8);
        for (int k = 0; k < 8; k++)
            if (k < got_q.size()) check($sformatf("stall lit%0d", k), got_q[k], plan1_words[k]);

        run_stream("hdr_only", 0, 4, 0, 0, 0, 0);
        run_stream("zero_ev", 5, 0, 0, 0, 0, 0);
        run_stream("spurious", 4, 2, 0, 0, 0, 3);

        // Abort by dropping pattern_en after the fifth write.
        pulse_start(10, 3);
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (PATTERN_we) n++;
            @(posedge clk); #1;
        end
        check("abort writes", 32'(n), 5);
        pattern_en = 1'b0;
        @(negedge clk);
        check("abort we", 32'(PATTERN_we), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("abort busy",  32'(pattern_busy),  0);
            check("abort done",  32'(pattern_done),  0);
            check("abort we2",   32'(PATTERN_we),    0);
            check("abort evcnt", 32'(pattern_evcnt), 0);
        end
        $display("abort after %0d writes", n);
        pattern_en = 1'b1;
        run_stream("restart", 10, 3, 0, 0, 0, 0);

        // Start while pattern_en is low is ignored.
        @(posedge clk); #1;
        pattern_en = 1'b0;
        pattern_nwords = 17'd2;
        pattern_nevents = 16'd2;
        pattern_start = 1'b1;
        @(posedge clk); #1;
        pattern_start = 1'b0;
        @(negedge clk);
        check("en_off busy", 32'(pattern_busy), 0);
        check("en_off done", 32'(pattern_done), 0);
        check("en_off we",   32'(PATTERN_we),   0);
        pattern_en = 1'b1;

        // Asynchronous reset in the middle of the second event.
        pulse_start(6, 3);
        n = 0;
        for (int c = 0; c < 40 && n < 9; c++) begin
            @(negedge clk);
            if (PATTERN_we) n++;
            if (n < 9) begin
                @(posedge clk); #1;
            end
        end
        check("prereset writes", 32'(n), 9);
        check("prereset evcnt", 32'(pattern_evcnt), 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        for (int r = 0; r < 6; r++) begin
            run_stream($sformatf("rand%0d", r), int'($urandom_range(0, 12)),
                       int'($urandom_range(1, 5)), int'($urandom_range(0, 60)),
                       0, 0, int'($urandom_range(1, 6)));
        end
        run_stream("long", 40, 2, 30, 10, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
